cpu_bus_capture: RTL

Synchronizes the asynchronous cartridge-port CPU strobes (`cpu_we`, `cpu_oe`) into the 50 MHz `clk` domain and glitch-filters them. It decodes accesses that fall in an 8-byte register window and queues write transactions in a small first-word-fall-through FIFO. It sits upstream of clocked register-window peripherals such as the hardware multiplier and divider: those consume one clean, single-clock write per CPU store instead of latching on raw strobe edges.

---
 rtl/cpu_bus_capture.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_capture.sv
// rtl/cpu_bus_capture.sv - CPU strobe synchronizer, glitch filter, register-window decoder and write queue
//
// Ports:
//   clk, rst        : master clock, synchronous active-high reset
//   cpu_addr/dato   : raw CPU address and write data, sampled every clock
//   cpu_we/cpu_oe   : raw active-low write/read strobes (asynchronous)
//   wr_valid/ready  : write-queue head handshake (pop on valid & ready)
//   wr_addr/wr_data : register index and data of the queue head
//   rd_pulse        : one-clock pulse per qualified in-window read
//   rd_addr         : register index of the most recent qualified read
//   fifo_level      : write-queue occupancy
//   ovf             : sticky, set when a write is dropped on a full queue

module cpu_bus_capture #(
    parameter int          SYNC_STAGES = 2,
    parameter int          FILT        = 2,
    parameter logic [20:0] WIN_BASE    = 21'h0FFFF8,
    parameter int          FIFO_DEPTH  = 4,
    localparam int         AW          = $clog2(FIFO_DEPTH),
    localparam int         LW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [20:0]   cpu_addr,
    input  logic [7:0]    cpu_dato,
    input  logic          cpu_we,
    input  logic          cpu_oe,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [2:0]    wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_pulse,
    output logic [2:0]    rd_addr,
    output logic [LW-1:0] fifo_level,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE_HI   = 2'd0,
        ACTIVE_LO = 2'd1,
        DISARMED  = 2'd2
    } filt_state_t;

    localparam logic [2:0]  FILT_M1 = 3'(FILT - 1);
    localparam logic [17:0] WIN_TAG = WIN_BASE[20:3];

    // ------------------------------------------------------------------
    // Strobe synchronizers (reset to the inactive level)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] we_sync;
    logic [SYNC_STAGES-1:0] oe_sync;

    // After reset the synchronizer outputs are the reset value, not real
    // samples. This chain marks when the last stage first holds a genuine
    // strobe sample; until then DISARMED ignores the (fake) high level so a
    // strobe held low through reset release can never arm and qualify.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   sample_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_sync <= '1;
            oe_sync <= '1;
            prime_q <= '0;
        end else begin
            we_sync <= {we_sync[SYNC_STAGES-2:0], cpu_we};
            oe_sync <= {oe_sync[SYNC_STAGES-2:0], cpu_oe};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sample_ok = prime_q[SYNC_STAGES-1];

    // index 0 = write strobe, index 1 = read strobe
    logic [1:0] strobe_s;
    assign strobe_s[0] = we_sync[SYNC_STAGES-1];
    assign strobe_s[1] = oe_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Bus sampling
    // ------------------------------------------------------------------
    logic [20:0] addr_q;
    logic [7:0]  data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= cpu_addr;
            data_q <= cpu_dato;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter FSMs, one per strobe
    // ------------------------------------------------------------------
    filt_state_t st_q [2];
    filt_state_t st_d [2];
    logic [2:0]  cnt_q [2];
    logic [2:0]  cnt_d [2];
    logic [1:0]  opp;
    logic [1:0]  qual;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= DISARMED;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        opp  = '0;
        qual = '0;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];

            // "opposite" means a sample that argues for leaving the state
            case (st_q[i])
                IDLE_HI:   opp[i] = ~strobe_s[i];
                ACTIVE_LO: opp[i] = strobe_s[i];
                default:   opp[i] = strobe_s[i] & sample_ok;
            endcase

            if (opp[i]) begin
                if (cnt_q[i] == FILT_M1) begin
                    // FILT-th consecutive opposite sample: switch now, so the
                    // qualification lands on this same edge
                    cnt_d[i] = '0;
                    case (st_q[i])
                        IDLE_HI: begin
                            st_d[i] = ACTIVE_LO;
                            qual[i] = 1'b1;
                        end
                        default: st_d[i] = IDLE_HI;
                    endcase
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic win_hit;
    logic push;
    logic rd_hit;

    assign win_hit = (addr_q[20:3] == WIN_TAG);
    assign push    = qual[0] & win_hit;
    // a simultaneous write wins; the read of that cycle is dropped
    assign rd_hit  = qual[1] & ~qual[0] & win_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pulse <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_pulse <= rd_hit;
            if (rd_hit) begin
                rd_addr <= addr_q[2:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write queue (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [2:0]    mem_a [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [LW-1:0] level;
    logic          pop;
    logic          push_ok;

    assign wr_valid = (level != '0);
    assign pop      = wr_valid & wr_ready;
    // a full queue still takes the push when the head leaves this cycle
    assign push_ok  = push & ((level != LW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_a[tail] <= addr_q[2:0];
            mem_d[tail] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push & ~push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // gate the head so stale storage never shows while the queue is empty
    assign wr_addr    = wr_valid ? mem_a[head] : 3'd0;
    assign wr_data    = wr_valid ? mem_d[head] : 8'd0;
    assign fifo_level = level;

endmodule
